// File: rtl/clock_ctrl_pkg.sv
// Shared types and constants for the clock mode/edit controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Provides the mode/state encoding, per-field maxima, blink-mask field
// indices and the packed time-of-day record used for edit/commit registers.
package clock_ctrl_pkg;

  // Encoding is exported on the mode output, so values are fixed.
  typedef enum logic [2:0] {
    ST_RUN    = 3'd0,
    ST_EDIT_H = 3'd1,
    ST_EDIT_M = 3'd2,
    ST_EDIT_S = 3'd3,
    ST_ALM_H  = 3'd4,
    ST_ALM_M  = 3'd5
  } state_t;

  localparam logic [5:0] MAX_HOUR = 6'd23;
  localparam logic [5:0] MAX_MIN  = 6'd59;
  localparam logic [5:0] MAX_SEC  = 6'd59;

  // Bit positions inside blink_mask {hour,min,sec}.
  localparam int F_HOU = 2;
  localparam int F_MIN = 1;
  localparam int F_SEC = 0;

  typedef struct packed {
    logic [5:0] hou;
    logic [5:0] min;
    logic [5:0] sec;
  } tod_t;

endpackage

// File: rtl/clock_mode_ctrl_tick_gen.sv
// Blink phase generator plus 1 Hz tick, both restartable by a key pulse.
// Latency: restart takes effect on the next clock edge (phase visible = 0).
// Backpressure: none; free-running counters.
//
// Ports:
//   clk_50Mhz, rst_n : clock, async active-low reset
//   restart          : one-cycle pulse, zeroes both counters and the phase
//   blink_phase      : toggles every CLK_HZ/(2*BLINK_HZ) cycles, 0 = visible
//   tick_1hz         : one-cycle pulse every CLK_HZ cycles after restart
module tick_gen #(
  parameter int CLK_HZ   = 50000000,
  parameter int BLINK_HZ = 2
) (
  input  logic clk_50Mhz,
  input  logic rst_n,
  input  logic restart,
  output logic blink_phase,
  output logic tick_1hz
);

  localparam int HALF = (CLK_HZ / (2 * BLINK_HZ) < 1) ? 1 : CLK_HZ / (2 * BLINK_HZ);
  localparam int HW   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int SW   = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

  logic [HW-1:0] half_cnt_q;
  logic [SW-1:0] sec_cnt_q;
  logic          half_end;

  assign half_end = (half_cnt_q == HW'(HALF - 1));
  assign tick_1hz = (sec_cnt_q == SW'(CLK_HZ - 1));

  always_ff @(posedge clk_50Mhz or negedge rst_n) begin
    if (!rst_n) begin
      half_cnt_q  <= '0;
      blink_phase <= 1'b0;
    end else if (restart) begin
      half_cnt_q  <= '0;
      blink_phase <= 1'b0;
    end else if (half_end) begin
      half_cnt_q  <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      half_cnt_q  <= half_cnt_q + 1'b1;
    end
  end

  // Restarted by keys too, so "seconds since last key" is exact.
  always_ff @(posedge clk_50Mhz or negedge rst_n) begin
    if (!rst_n) begin
      sec_cnt_q <= '0;
    end else if (restart || tick_1hz) begin
      sec_cnt_q <= '0;
    end else begin
      sec_cnt_q <= sec_cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/clock_mode_ctrl.sv
// Mode/edit controller for time-of-day counter and alarm registers.
// Latency: one cycle from key pulse to state/output update; load is a 1-cycle strobe.
// Backpressure: none; key pulses are consumed the cycle they arrive.
//
// Optional feature macro: CLOCK_CTRL_TIMEOUT_EN (abandon edits after
// TIMEOUT_S seconds without a key pulse; absent = edits persist).
//
// Ports:
//   clk_50Mhz, rst_n                   : clock, async active-low reset
//   key_mode/key_inc/key_dec/key_ok    : one-cycle key events
//   cur_hou/cur_min/cur_sec            : live time, snapshotted on entering edit
//   set_hou/set_min/set_sec, load      : committed time + strobe to counter
//   stop_clk                           : holds counter while time is edited
//   alm_hou/alm_min, alm_en            : committed alarm and arm flag
//   blink_mask                         : {hour,min,sec} blank request
//   mode                               : current state encoding
module clock_mode_ctrl
  import clock_ctrl_pkg::*;
#(
  parameter int CLK_HZ    = 50000000,
  parameter int BLINK_HZ  = 2,
  parameter int TIMEOUT_S = 10
) (
  input  logic       clk_50Mhz,
  input  logic       rst_n,
  input  logic       key_mode,
  input  logic       key_inc,
  input  logic       key_dec,
  input  logic       key_ok,
  input  logic [5:0] cur_hou,
  input  logic [5:0] cur_min,
  input  logic [5:0] cur_sec,
  output logic [5:0] set_hou,
  output logic [5:0] set_min,
  output logic [5:0] set_sec,
  output logic       load,
  output logic       stop_clk,
  output logic [5:0] alm_hou,
  output logic [5:0] alm_min,
  output logic       alm_en,
  output logic [2:0] blink_mask,
  output logic [2:0] mode
);

  state_t     state_q, state_nxt;
  tod_t       edit_q, edit_nxt;
  tod_t       set_q, set_nxt;
  logic [5:0] ae_hou_q, ae_hou_nxt;
  logic [5:0] ae_min_q, ae_min_nxt;
  logic [5:0] alm_hou_q, alm_hou_nxt;
  logic [5:0] alm_min_q, alm_min_nxt;
  logic       alm_en_q, alm_en_nxt;
  logic       load_nxt;
  logic       any_key;
  logic       blink_phase;
  logic       tick_1hz;
  logic       timeout_hit;

  assign any_key = key_mode | key_inc | key_dec | key_ok;

  tick_gen #(
    .CLK_HZ  (CLK_HZ),
    .BLINK_HZ(BLINK_HZ)
  ) u_tick_gen (
    .clk_50Mhz  (clk_50Mhz),
    .rst_n      (rst_n),
    .restart    (any_key),
    .blink_phase(blink_phase),
    .tick_1hz   (tick_1hz)
  );

`ifdef CLOCK_CTRL_TIMEOUT_EN
  localparam int TW = (TIMEOUT_S > 0) ? $clog2(TIMEOUT_S + 1) : 1;
  logic [TW-1:0] to_cnt_q;

  always_ff @(posedge clk_50Mhz or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt_q <= '0;
    end else if (state_q == ST_RUN || any_key) begin
      to_cnt_q <= '0;
    end else if (tick_1hz) begin
      to_cnt_q <= to_cnt_q + 1'b1;
    end
  end

  assign timeout_hit = (state_q != ST_RUN) && tick_1hz && (to_cnt_q == TW'(TIMEOUT_S - 1));
`else
  localparam int UNUSED_TIMEOUT_S = TIMEOUT_S;
  logic unused_tick_1hz;
  assign unused_tick_1hz = tick_1hz;
  assign timeout_hit     = 1'b0;
`endif

  // Wrap step for one field. An out-of-range value (only possible from a
  // raw cur_* snapshot) normalises to 0 on inc and to max on dec.
  function automatic logic [5:0] step(input logic [5:0] v, input logic [5:0] max_v,
                                      input logic up);
    if (up) step = (v >= max_v) ? 6'd0 : v + 6'd1;
    else    step = (v == 6'd0 || v > max_v) ? max_v : v - 6'd1;
  endfunction

  always_ff @(posedge clk_50Mhz or negedge rst_n) begin
    if (!rst_n) state_q <= ST_RUN;
    else        state_q <= state_nxt;
  end

  // Priority: mode > ok > inc > dec; lower-priority keys in the same cycle are dropped.
  always_comb begin
    state_nxt   = state_q;
    edit_nxt    = edit_q;
    set_nxt     = set_q;
    ae_hou_nxt  = ae_hou_q;
    ae_min_nxt  = ae_min_q;
    alm_hou_nxt = alm_hou_q;
    alm_min_nxt = alm_min_q;
    alm_en_nxt  = alm_en_q;
    load_nxt    = 1'b0;
    if (key_mode) begin
      case (state_q)
        ST_RUN: begin
          state_nxt = ST_EDIT_H;
          edit_nxt  = {cur_hou, cur_min, cur_sec};
        end
        ST_EDIT_H: state_nxt = ST_EDIT_M;
        ST_EDIT_M: state_nxt = ST_EDIT_S;
        ST_EDIT_S: begin
          // Time edit is abandoned without a load; counter simply resumes.
          state_nxt  = ST_ALM_H;
          ae_hou_nxt = alm_hou_q;
          ae_min_nxt = alm_min_q;
        end
        ST_ALM_H: state_nxt = ST_ALM_M;
        default:  state_nxt = ST_RUN;
      endcase
    end else if (key_ok) begin
      case (state_q)
        ST_RUN: alm_en_nxt = ~alm_en_q;
        ST_EDIT_H, ST_EDIT_M, ST_EDIT_S: begin
          set_nxt   = edit_q;
          load_nxt  = 1'b1;
          state_nxt = ST_RUN;
        end
        default: begin
          alm_hou_nxt = ae_hou_q;
          alm_min_nxt = ae_min_q;
          alm_en_nxt  = 1'b1;
          state_nxt   = ST_RUN;
        end
      endcase
    end else if (key_inc || key_dec) begin
      case (state_q)
        ST_EDIT_H: edit_nxt.hou = step(edit_q.hou, MAX_HOUR, key_inc);
        ST_EDIT_M: edit_nxt.min = step(edit_q.min, MAX_MIN, key_inc);
        ST_EDIT_S: edit_nxt.sec = step(edit_q.sec, MAX_SEC, key_inc);
        ST_ALM_H:  ae_hou_nxt   = step(ae_hou_q, MAX_HOUR, key_inc);
        ST_ALM_M:  ae_min_nxt   = step(ae_min_q, MAX_MIN, key_inc);
        default: ;
      endcase
    end else if (timeout_hit) begin
      state_nxt = ST_RUN;
    end
  end

  always_ff @(posedge clk_50Mhz or negedge rst_n) begin
    if (!rst_n) begin
      edit_q    <= '0;
      set_q     <= '0;
      ae_hou_q  <= '0;
      ae_min_q  <= '0;
      alm_hou_q <= '0;
      alm_min_q <= '0;
      alm_en_q  <= 1'b0;
      load      <= 1'b0;
    end else begin
      edit_q    <= edit_nxt;
      set_q     <= set_nxt;
      ae_hou_q  <= ae_hou_nxt;
      ae_min_q  <= ae_min_nxt;
      alm_hou_q <= alm_hou_nxt;
      alm_min_q <= alm_min_nxt;
      alm_en_q  <= alm_en_nxt;
      load      <= load_nxt;
    end
  end

  // Leaving EDIT_S (commit, ALM_H or timeout) drops stop_clk with the state,
  // which lines up with the load strobe on a commit.
  assign stop_clk = (state_q == ST_EDIT_H) || (state_q == ST_EDIT_M) || (state_q == ST_EDIT_S);

  always_comb begin
    blink_mask = 3'b000;
    case (state_q)
      ST_EDIT_H, ST_ALM_H: blink_mask[F_HOU] = blink_phase;
      ST_EDIT_M, ST_ALM_M: blink_mask[F_MIN] = blink_phase;
      ST_EDIT_S:           blink_mask[F_SEC] = blink_phase;
      default: ;
    endcase
  end

  assign set_hou = set_q.hou;
  assign set_min = set_q.min;
  assign set_sec = set_q.sec;
  assign alm_hou = alm_hou_q;
  assign alm_min = alm_min_q;
  assign alm_en  = alm_en_q;
  assign mode    = state_q;

endmodule

// File: doc/clock_mode_ctrl.md
Name: clock_mode_ctrl

Overview:
Mode/edit controller that sequences the time-of-day counter and alarm registers of the digital clock. It takes one-cycle key events from the key scanner and snapshots live time into an edit buffer. It issues a load strobe plus hold (stop_clk) to the running counter, and drives per-field blink masks to the 7-seg scanner. It also owns the alarm time and alarm enable consumed by the ring/music logic.

Parameters:
CLK_HZ, 50000000, input clock frequency in Hz
BLINK_HZ, 2, blink frequency of the field being edited
TIMEOUT_S, 10, seconds of key inactivity before an edit is abandoned (TIMEOUT_EN only)

Ports:
clk_50Mhz  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
key_mode  in  1  one-cycle pulse: advance mode
key_inc  in  1  one-cycle pulse: increment current field
key_dec  in  1  one-cycle pulse: decrement current field
key_ok  in  1  one-cycle pulse: commit / toggle alarm enable
cur_hou, cur_min, cur_sec  in  6 each  live time from counter (binary)
set_hou, set_min, set_sec  out  6 each  value to load into counter
load  out  1  one-cycle load strobe to counter
stop_clk  out  1  holds counter while editing time
alm_hou, alm_min  out  6 each  committed alarm time
alm_en  out  1  alarm armed
blink_mask  out  3  {hour,min,sec} blank request, 1 = blank that digit pair
mode  out  3  current state encoding, for display/LEDs

Behaviour:
- Clock and reset: single clock clk_50Mhz; reset is asynchronous, active-low (rst_n).
- Reset values: all outputs 0 and state RUN; alarm regs 0:00; edit regs 0.
- States (mode encoding): RUN=0, EDIT_H=1, EDIT_M=2, EDIT_S=3, ALM_H=4, ALM_M=5.
- key_mode transitions: RUN->EDIT_H->EDIT_M->EDIT_S->ALM_H->ALM_M->RUN.
- Entering EDIT_H from RUN: edit regs <= cur_*, sampled on the key_mode cycle. stop_clk=1 from the next cycle through EDIT_S.
- Leaving EDIT_S via key_mode into ALM_H: no load. Counter resumes from its unmodified value (stop_clk drops on entering ALM_H).
- Entering ALM_H: alarm edit regs <= alm_hou/alm_min.
- key_inc/key_dec in EDIT_*/ALM_*: modify only the current field, with wrap.
  - Hours: 23+1=0, 0-1=23.
  - Minutes/seconds: 59+1=0, 0-1=59.
- key_ok in EDIT_H/M/S:
  - Next cycle: set_* = edit regs, load=1 for exactly one cycle, state=RUN.
  - stop_clk falls in the same cycle load is high.
  - set_* hold their value until the next commit.
- key_ok in ALM_H/ALM_M: alm_hou/alm_min <= edit values, alm_en <= 1, state=RUN.
- key_ok in RUN: toggle alm_en.
- Simultaneous pulses: priority mode > ok > inc > dec. Lower-priority pulses in that cycle are dropped.
- Blink:
  - Half-period counter of CLK_HZ/(2*BLINK_HZ) cycles.
  - Only the current field's mask bit toggles; other bits are 0; RUN gives 000.
  - Any key pulse restarts the phase at visible (bit 0) so an edited value is seen immediately.
  - In alarm states, the hour/min bits refer to the alarm field.
- Inputs cur_* are trusted in range; out-of-range values are snapshotted as-is and normalised by the next inc/dec wrap (>max after inc -> 0).

Optional Feature:
CLOCK_CTRL_TIMEOUT_EN
- Defined: a 1 Hz tick counts seconds since the last key pulse in any non-RUN state. Reaching TIMEOUT_S returns to RUN with no load and no alarm commit, and stop_clk drops. Any key pulse clears the count.
- Undefined: edit states persist indefinitely; the timeout counter is not synthesised.

Decomposition:
- Package clock_ctrl_pkg:
  - state encoding constants ST_RUN..ST_ALM_M
  - MAX_HOUR=23, MAX_MIN=59, MAX_SEC=59
  - field index constants F_HOU=2, F_MIN=1, F_SEC=0
- Sub-module tick_gen (parameters CLK_HZ, BLINK_HZ):
  - blink toggle with synchronous restart input
  - 1 Hz pulse for the timeout
- Wrap arithmetic stays in the main FSM.

Test Plan:
- Bench parameters: CLK_HZ=16, BLINK_HZ=2, TIMEOUT_S=3.
- Reset mid-EDIT_M with stop_clk=1 -> next cycle all outputs 0, mode=0, alm_en=0.
- cur=12:34:56, key_mode, inc x12, ok -> load pulse exactly one cycle with set=00:34:56. stop_clk high from cycle after key_mode until the load cycle.
- EDIT_M, edit min=0, dec -> 59. EDIT_S=59, inc -> 0. Hour=0, dec -> 23.
- key_mode x4 into ALM_H, inc x7, mode, dec, ok -> alm=07:59, alm_en=1, no load. Then ok in RUN -> alm_en=0.
- key_mode and key_inc in the same cycle from EDIT_H -> state EDIT_M, hour unchanged.
- TIMEOUT_EN: enter EDIT_H, no keys for 3 ticks of 1 Hz -> mode=0, stop_clk=0, load never asserted. Without the macro -> still EDIT_H after 10 ticks. blink_mask=100 toggles every 4 cycles.
